scs8hd_andn_dbsync: RTL and testbench
=====================================

# scs8hd_andn_dbsync

Parametrised N-input AND cell with per-input synchronisers, a registered raw output and a debounce filter.
- Successor to the fixed two-input combinational AND in the scs8hd library.
- Intended for asynchronous qualifier signals (power-good, lock, ready strobes) that must be ANDed and presented glitch-free to a single clock domain.
- Outputs a filtered level plus single-cycle edge pulses.

## Interface
Parameters:
- N, 2: number of AND inputs; legal 2..8.
- SYNC_STAGES, 2: synchroniser flops per input; legal 0..3. 0 means A feeds the AND directly.
- HOLD, 3: consecutive cycles the raw AND must differ from X before X follows; legal 1..255.
- CW, $clog2(HOLD+1): derived counter width; not user-overridden.

Ports:
- CLK  in  1  rising-edge clock.
- RESETB  in  1  reset, asynchronous assert, active-low. Release is synchronous to CLK externally.
- A  in  N  asynchronous inputs.
- EN  in  1  filter enable. 0 freezes X and clears the qualification counter.
- X  out  1  debounced AND of all inputs.
- XRAW  out  1  registered, unfiltered AND of the synchronised inputs.
- RISE  out  1  one-cycle pulse when X goes 0->1.
- FALL  out  1  one-cycle pulse when X goes 1->0.
- vpwr, vgnd, vpb, vnb  in  1  present only under SC_USE_PG_PIN. When absent, they are tied supply1/supply0.

## Operation
- **Synchroniser:** each A[i] passes through SYNC_STAGES flops, reset 0, giving a_s.
- **Raw AND:** and_s = &a_s; XRAW <= and_s each edge.
- **Filter state:** X (reset 0) and counter cnt[CW-1:0] (reset 0). Conceptual states are LOW, QUAL_HI, HIGH and QUAL_LO, where qualifying means cnt != 0 or XRAW != X.
- **Filter rules, each edge, in priority order:**
  - EN=0: cnt<=0, X holds.
  - XRAW==X: cnt<=0.
  - XRAW!=X and cnt==HOLD-1: X<=XRAW, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- **Counter range:** cnt never exceeds HOLD-1, so there is no wrap.
- **Edge pulses:** RISE/FALL are registered. Each is high for exactly the one cycle in which X first shows its new value, and both are 0 otherwise.
- **Mutual exclusion:** RISE and FALL are never high together.
- **Reset:** RESETB low asynchronously clears all sync flops, XRAW, X, cnt, RISE and FALL to 0, including mid-qualification.

## Timing
- Input-to-XRAW latency: SYNC_STAGES+1 edges.
- XRAW-to-X latency: HOLD edges of stable XRAW with EN=1.
- Total A-to-X latency: SYNC_STAGES+1+HOLD edges.
- A pulse on XRAW shorter than HOLD cycles never reaches X. cnt restarts from 0 on each re-qualification.
- HOLD=1: X is XRAW delayed by one edge.
- EN deasserted in the same cycle cnt reaches HOLD-1: EN wins, X does not toggle and no pulse is generated.
- EN reasserted: qualification restarts at cnt=0 on the first edge with EN=1.
- After RESETB release with A all 1: X rises at edge SYNC_STAGES+1+HOLD, counting from the first edge after release.

## Structure
- Package scs8hd_andn_pkg holds:
  - legal-range constants N_MAX=8, SYNC_MAX=3, HOLD_MAX=255;
  - a filter-state enum {LOW, QUAL_HI, HIGH, QUAL_LO} used for debug visibility.
- Parameter-range checks are elaboration-time assertions using those constants.
- Sub-module scs8hd_sync_n: a vectorised N-bit, SYNC_STAGES-deep reset-to-0 synchroniser, instanced once.
- The filter and pulse logic stay in the top module.
- The PG variant routes X through the existing power-good UDP wrapper, identical to the other library cells.

## Test plan
- Basic rise: N=4, SYNC_STAGES=2, HOLD=3. A=4'hF applied before edge 1. Required: XRAW=1 after edge 3, X=1 after edge 6, RISE high only in the cycle after edge 6.
- Glitch rejection: from X=0, hold A=4'hF so that XRAW is high for 2 cycles, then A=4'h7. Required: X stays 0, RISE never asserts, cnt returns to 0.
- Fall path: from X=1, A=4'hE held. Required: XRAW=0 after 3 edges, X=0 three edges later, FALL high for 1 cycle.
- EN freeze: start qualifying (cnt=2) and drop EN in that cycle. Required: X unchanged and cnt=0. On re-enable, X rises exactly HOLD edges later.
- Reset mid-qualification: RESETB low while cnt=2 and X=0, then release with A=4'hF. Required: all outputs 0 immediately, and X=1 exactly 6 edges after release.
- Corner parameters: SYNC_STAGES=0, HOLD=1, N=2, A=2'b11. Required: XRAW=1 after edge 1, X=1 after edge 2.

Source files
------------

// File: rtl/scs8hd_andn_pkg.sv
// Shared constants and types for the scs8hd_andn_dbsync cell.
// Filter-state enum gives debug visibility into the debounce filter.
package scs8hd_andn_pkg;

    localparam int N_MAX    = 8;
    localparam int SYNC_MAX = 3;
    localparam int HOLD_MAX = 255;

    typedef enum logic [1:0] {
        LOW,
        QUAL_HI,
        HIGH,
        QUAL_LO
    } filt_state_e;

    function automatic filt_state_e filt_state(
        input logic x,
        input logic busy
    );
        filt_state_e s;
        unique case (1'b1)
            (!x && !busy): s = LOW;
            (!x &&  busy): s = QUAL_HI;
            ( x && !busy): s = HIGH;
            default:       s = QUAL_LO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scs8hd_andn_dbsync_sync_n.sv
// Vectorised N-bit reset-to-0 synchroniser, STAGES flops deep.
// STAGES=0 degenerates to a straight wire.
module scs8hd_sync_n #(
    parameter int N      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    if (STAGES == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_ni;
        assign q_o        = d_i;
    end else begin : g_ff
        logic [N-1:0] stg_q [STAGES];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < STAGES; i++) begin
                    stg_q[i] <= '0;
                end
            end else begin
                stg_q[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    stg_q[i] <= stg_q[i-1];
                end
            end
        end

        assign q_o = stg_q[STAGES-1];
    end

endmodule

// File: rtl/scs8hd_andn_dbsync.sv
// N-input AND with per-input synchronisers, registered raw output,
// debounce filter and single-cycle edge pulses.
module scs8hd_andn_dbsync
    import scs8hd_andn_pkg::*;
#(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 3
) (
    input  logic         CLK,
    input  logic         RESETB,
    input  logic [N-1:0] A,
    input  logic         EN,
    output logic         X,
    output logic         XRAW,
    output logic         RISE,
    output logic         FALL
`ifdef SC_USE_PG_PIN
    ,
    input  logic         vpwr,
    input  logic         vgnd,
    input  logic         vpb,
    input  logic         vnb
`endif
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    if (N < 2 || N > N_MAX) begin : g_bad_n
        $error("scs8hd_andn_dbsync: N out of range");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("scs8hd_andn_dbsync: SYNC_STAGES out of range");
    end
    if (HOLD < 1 || HOLD > HOLD_MAX) begin : g_bad_hold
        $error("scs8hd_andn_dbsync: HOLD out of range");
    end

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    logic [N-1:0]  a_s;
    logic          and_s;
    logic          xraw_q;
    logic          x_q,    x_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy;
    logic          pg;
    filt_state_e   state;

    scs8hd_sync_n #(
        .N      (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (CLK),
        .rst_ni (RESETB),
        .d_i    (A),
        .q_o    (a_s)
    );

    assign and_s = &a_s;
    assign busy  = (cnt_q != '0) || (xraw_q != x_q);
    assign state = filt_state(x_q, busy);

    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!EN) begin
            cnt_d = '0;
        end else if (xraw_q == x_q) begin
            cnt_d = '0;
        end else if (cnt_q == HOLD_M1) begin
            // Qualification complete: direction comes from the state
            x_d    = xraw_q;
            cnt_d  = '0;
            rise_d = (state == QUAL_HI);
            fall_d = (state == QUAL_LO);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            xraw_q <= 1'b0;
            x_q    <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            xraw_q <= and_s;
            x_q    <= x_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Power-good gating: X forced low when the cell is unpowered
    assign pg   = vpwr & vpb & ~vgnd & ~vnb;
    assign X    = x_q & pg;
    assign XRAW = xraw_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: tb/tb_scs8hd_andn_dbsync.sv
// Self-checking bench for scs8hd_andn_dbsync: directed scenarios plus
// randomized stimulus against a behavioural edge-history model.
module tb_scs8hd_andn_dbsync;

    localparam int N = 4;
    localparam int S = 2;
    localparam int H = 3;

    logic       clk  = 1'b0;
    logic       rstb = 1'b1;
    logic [3:0] a    = '0;
    logic       en   = 1'b1;
    logic       x, xraw, rise, fall;

    logic [1:0] a2  = '0;
    logic       en2 = 1'b1;
    logic       x2, xraw2, rise2, fall2;

    int checks = 0;
    int errors = 0;

    // Model: history of sampled ANDs and the run of qualifying edges
    int   ek;
    bit   andh[$];
    bit   qual[$];
    bit   xr_m, x_m, rise_m, fall_m;
    logic [1:0] cnt_m;

    always #5 clk = ~clk;

    scs8hd_andn_dbsync #(
        .N           (N),
        .SYNC_STAGES (S),
        .HOLD        (H)
    ) u_dut (
        .CLK    (clk),
        .RESETB (rstb),
        .A      (a),
        .EN     (en),
        .X      (x),
        .XRAW   (xraw),
        .RISE   (rise),
        .FALL   (fall)
    );

    scs8hd_andn_dbsync #(
        .N           (2),
        .SYNC_STAGES (0),
        .HOLD        (1)
    ) u_dut2 (
        .CLK    (clk),
        .RESETB (rstb),
        .A      (a2),
        .EN     (en2),
        .X      (x2),
        .XRAW   (xraw2),
        .RISE   (rise2),
        .FALL   (fall2)
    );

    task automatic model_reset();
        ek = 0;
        andh.delete();
        qual.delete();
        xr_m   = 1'b0;
        x_m    = 1'b0;
        rise_m = 1'b0;
        fall_m = 1'b0;
        cnt_m  = 2'd0;
    endtask

    task automatic model_edge();
        bit oxr, ox;
        oxr = xr_m;
        ox  = x_m;
        andh.push_back(&a);
        ek++;
        xr_m   = (ek > S) ? andh[ek-S-1] : 1'b0;
        rise_m = 1'b0;
        fall_m = 1'b0;
        if (en && (oxr != ox)) qual.push_back(1'b1);
        else qual.delete();
        if (qual.size() == H) begin
            x_m    = oxr;
            rise_m = oxr;
            fall_m = ~oxr;
            qual.delete();
        end
        cnt_m = 2'(qual.size());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        a    = 4'hF;
        a2   = 2'b11;
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({xraw, x, rise, fall, xraw2, x2, rise2, fall2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: got %b exp 00000000",
                     {xraw, x, rise, fall, xraw2, x2, rise2, fall2});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({xraw, x, u_dut.cnt_q} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: got xraw/x/cnt=%b exp 0000",
                     {xraw, x, u_dut.cnt_q});
        end
        a  = '0;
        a2 = '0;
        rstb = 1'b1;
    endtask

    task automatic test_basic_rise();
        do_reset();
        a = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL basic_rise e%0d: got %b exp %b", i,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
            if (i == 3) begin
                checks++;
                if (xraw !== 1'b1) begin
                    errors++;
                    $display("FAIL rise_xraw_e3: got %b exp 1", xraw);
                end
            end
            if (i == 5 || i == 6 || i == 7) begin
                checks++;
                if ({x, rise} !== {1'(i >= 6), 1'(i == 6)}) begin
                    errors++;
                    $display("FAIL rise_x_e%0d: got x/rise=%b exp %b", i,
                             {x, rise}, {1'(i >= 6), 1'(i == 6)});
                end
            end
        end
    endtask

    task automatic test_fall();
        int nfall = 0;
        int fall_at = 0;
        a = 4'hE;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL fall e%0d: got %b exp %b", i,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
            if (fall === 1'b1) begin
                nfall++;
                fall_at = i;
            end
        end
        checks++;
        if (nfall != 1 || fall_at != 6 || x !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse: got n=%0d at=%0d x=%b exp 1 6 0",
                     nfall, fall_at, x);
        end
    endtask

    task automatic test_glitch();
        int nrise = 0;
        do_reset();
        a = 4'h0;
        repeat (4) step();
        a = 4'hF;
        step();
        step();
        a = 4'h7;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL glitch e%0d: got %b exp %b", i,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
            if (rise === 1'b1) nrise++;
        end
        checks++;
        if (nrise != 0 || x !== 1'b0 || u_dut.cnt_q !== 2'd0) begin
            errors++;
            $display("FAIL glitch_final: got rises=%0d x=%b cnt=%0d exp 0 0 0",
                     nrise, x, u_dut.cnt_q);
        end
    endtask

    task automatic test_en_freeze();
        int guard = 0;
        int n = 0;
        do_reset();
        en = 1'b1;
        a  = 4'hF;
        while (cnt_m != 2'd2 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 20 || u_dut.cnt_q !== 2'd2) begin
            errors++;
            $display("FAIL en_reach_cnt2: got cnt=%0d exp 2", u_dut.cnt_q);
        end
        en = 1'b0;
        step();
        checks++;
        if ({x, rise, u_dut.cnt_q} !== {x_m, rise_m, cnt_m} ||
            {x, u_dut.cnt_q} !== 3'b000) begin
            errors++;
            $display("FAIL en_freeze: got x/rise/cnt=%b exp 0000",
                     {x, rise, u_dut.cnt_q});
        end
        repeat (3) step();
        en = 1'b1;
        while (x !== 1'b1 && n < 20) begin
            step();
            n++;
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL en_resume e%0d: got %b exp %b", n,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
        end
        checks++;
        if (n != H) begin
            errors++;
            $display("FAIL en_latency: got %0d edges exp %0d", n, H);
        end
    endtask

    task automatic test_reset_midqual();
        int guard = 0;
        int rise_at = 0;
        do_reset();
        a = 4'hF;
        while (cnt_m != 2'd2 && guard < 20) begin
            step();
            guard++;
        end
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({xraw, x, rise, fall, u_dut.cnt_q} !== 6'b0) begin
            errors++;
            $display("FAIL midqual_reset: got %b exp 000000",
                     {xraw, x, rise, fall, u_dut.cnt_q});
        end
        @(posedge clk);
        #1;
        rstb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL midqual e%0d: got %b exp %b", i,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
            if (rise === 1'b1 && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != S + 1 + H) begin
            errors++;
            $display("FAIL midqual_latency: got %0d exp %0d", rise_at, S + 1 + H);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 1; i <= 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 2) == 0) ? 4'(($urandom())) : 4'hF;
            end else if ($urandom_range(0, 5) == 0) begin
                a = 4'(($urandom()));
            end
            en = ($urandom_range(0, 15) != 0);
            step();
            checks++;
            if ({xraw, x, rise, fall, u_dut.cnt_q} !==
                {xr_m, x_m, rise_m, fall_m, cnt_m}) begin
                errors++;
                $display("FAIL random e%0d: got %b exp %b", i,
                         {xraw, x, rise, fall, u_dut.cnt_q},
                         {xr_m, x_m, rise_m, fall_m, cnt_m});
            end
            checks++;
            if (rise === 1'b1 && fall === 1'b1) begin
                errors++;
                $display("FAIL random_excl e%0d: got rise=1 fall=1 exp not both", i);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_corner();
        logic [3:0] exp_v [1:5];
        exp_v[1] = 4'b1000;
        exp_v[2] = 4'b1110;
        exp_v[3] = 4'b1100;
        exp_v[4] = 4'b0100;
        exp_v[5] = 4'b0001;
        do_reset();
        en2 = 1'b1;
        a2  = 2'b11;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if ({xraw2, x2, rise2, fall2} !== exp_v[i]) begin
                errors++;
                $display("FAIL corner e%0d: got xraw/x/rise/fall=%b exp %b", i,
                         {xraw2, x2, rise2, fall2}, exp_v[i]);
            end
            if (i == 3) a2 = 2'b01;
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_fall();
        test_glitch();
        test_en_freeze();
        test_reset_midqual();
        test_random();
        test_corner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
